ula_iterativa: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 8-bit ULA.
- Same operation set and Sel_Op encoding, at any operand width.
- Multiplication uses an iterative shift-add unit; division uses a restoring divider. Neither uses a combinational `*`, `/` or `%`.
- Adds a valid/ready handshake, registered outputs and status flags.
- Sits between the datapath operand registers and the result bus.

---
 rtl/ula_iterativa.sv | 198 +++++++++++++++++++
 tb/tb_ula_iterativa.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ula_iterativa.sv
// Multi-cycle ALU with a valid/ready request handshake and registered result and flags.
// mul is an iterative shift-add; div/rem is a restoring divider, one step per clock.
//
// state  | meaning
// OCIOSO | idle; Pronto=1; single-cycle ops complete on the accept edge
// CALC   | mul/div/rem iterating; Pronto=0; finishes on the step where the counter hits 0
module ula_iterativa #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Entrada_Valida,
  output logic                 Pronto,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [3:0]           Sel_Op,
  output logic [2*WIDTH-1:0]   Resultado,
  output logic                 Saida_Valida,
  output logic                 Zero,
  output logic                 Carry,
  output logic                 Overflow,
  output logic                 DivZero,
  output logic                 Erro
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_QUO  = 4'b0011;
  localparam logic [3:0] OP_REM  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;

  typedef enum logic {OCIOSO, CALC} estado_t;

  estado_t              estado;
  logic [CW-1:0]        cnt;
  logic [3:0]           op_reg;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     div_rem;
  logic [WIDTH-1:0]     div_q;
  logic [WIDTH-1:0]     divisor;

  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       dif_ext;
  logic [2*WIDTH-1:0]   s_res;
  logic                 s_carry;
  logic                 s_ovf;
  logic                 s_dz;
  logic                 s_err;
  logic                 is_multi;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     q_nxt;
  logic [2*WIDTH-1:0]   calc_res;

  // Single-cycle result path, straight from the live inputs at the accept edge.
  always_comb begin
    sum_ext = {1'b0, A} + {1'b0, B};
    dif_ext = {1'b0, A} - {1'b0, B};
    s_res   = '0;
    s_carry = 1'b0;
    s_ovf   = 1'b0;
    s_dz    = 1'b0;
    s_err   = 1'b0;
    case (Sel_Op)
      OP_ADD: begin
        s_res   = {{(WIDTH-1){1'b0}}, sum_ext};
        s_carry = sum_ext[WIDTH];
        s_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_res   = {{WIDTH{1'b0}}, dif_ext[WIDTH-1:0]};
        s_carry = dif_ext[WIDTH];
        s_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (dif_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL:  s_res = '0;
      OP_QUO: begin
        s_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        s_dz  = (B == '0);
      end
      OP_REM: begin
        s_res = {{WIDTH{1'b0}}, A};
        s_dz  = (B == '0);
      end
      OP_AND:  s_res = {{WIDTH{1'b0}}, A & B};
      OP_OR:   s_res = {{WIDTH{1'b0}}, A | B};
      OP_NAND: s_res = {{WIDTH{1'b0}}, ~(A & B)};
      OP_NOR:  s_res = {{WIDTH{1'b0}}, ~(A | B)};
      OP_XOR:  s_res = {{WIDTH{1'b0}}, A ^ B};
      OP_NOT:  s_res = {{WIDTH{1'b0}}, ~A};
      OP_CMP: begin
        if (A == B)     s_res = '0;
        else if (A < B) s_res = {{(2*WIDTH-2){1'b0}}, 2'd1};
        else            s_res = {{(2*WIDTH-2){1'b0}}, 2'd2};
      end
      default: s_err = 1'b1;
    endcase
    is_multi = (Sel_Op == OP_MUL) || (((Sel_Op == OP_QUO) || (Sel_Op == OP_REM)) && (B != '0));
  end

  // One iteration step; the final step's output feeds the result register directly.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    prod_nxt  = {mul_sum, prod[WIDTH-1:1]};
    div_shift = {div_rem, div_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, divisor};
    if (div_trial[WIDTH]) begin
      rem_nxt = div_shift[WIDTH-1:0];
      q_nxt   = {div_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = div_trial[WIDTH-1:0];
      q_nxt   = {div_q[WIDTH-2:0], 1'b1};
    end
    if (op_reg == OP_MUL)      calc_res = prod_nxt;
    else if (op_reg == OP_QUO) calc_res = {{WIDTH{1'b0}}, q_nxt};
    else                       calc_res = {{WIDTH{1'b0}}, rem_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      op_reg       <= '0;
      prod         <= '0;
      mcand        <= '0;
      div_rem      <= '0;
      div_q        <= '0;
      divisor      <= '0;
      Pronto       <= 1'b1;
      Resultado    <= '0;
      Saida_Valida <= 1'b0;
      Zero         <= 1'b1;
      Carry        <= 1'b0;
      Overflow     <= 1'b0;
      DivZero      <= 1'b0;
      Erro         <= 1'b0;
    end else begin
      Saida_Valida <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (Entrada_Valida) begin
            if (is_multi) begin
              estado  <= CALC;
              Pronto  <= 1'b0;
              cnt     <= CW'(WIDTH);
              op_reg  <= Sel_Op;
              prod    <= {{WIDTH{1'b0}}, A};
              mcand   <= B;
              div_rem <= '0;
              div_q   <= A;
              divisor <= B;
            end else begin
              Resultado    <= s_res;
              Zero         <= (s_res == '0);
              Carry        <= s_carry;
              Overflow     <= s_ovf;
              DivZero      <= s_dz;
              Erro         <= s_err;
              Saida_Valida <= 1'b1;
            end
          end
        end
        CALC: begin
          prod    <= prod_nxt;
          div_rem <= rem_nxt;
          div_q   <= q_nxt;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            estado       <= OCIOSO;
            Pronto       <= 1'b1;
            Resultado    <= calc_res;
            Zero         <= (calc_res == '0);
            Carry        <= 1'b0;
            Overflow     <= 1'b0;
            DivZero      <= 1'b0;
            Erro         <= 1'b0;
            Saida_Valida <= 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_iterativa.sv
// Directed bench for ula_iterativa: 8-bit instance for the operation set and handshake,
// plus a 16-bit instance for the wide multiply.
module tb_ula_iterativa;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        ev8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  sel8 = '0;
  logic        p8, sv8, z8, c8, o8, dz8, e8;
  logic [15:0] res8;

  logic        ev16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  sel16 = '0;
  logic        p16, sv16, z16, c16, o16, dz16, e16;
  logic [31:0] res16;

  int n_chk = 0;
  int n_pass = 0;

  ula_iterativa #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Entrada_Valida(ev8), .Pronto(p8),
    .A(a8), .B(b8), .Sel_Op(sel8), .Resultado(res8), .Saida_Valida(sv8),
    .Zero(z8), .Carry(c8), .Overflow(o8), .DivZero(dz8), .Erro(e8)
  );

  ula_iterativa #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .Entrada_Valida(ev16), .Pronto(p16),
    .A(a16), .B(b16), .Sel_Op(sel16), .Resultado(res16), .Saida_Valida(sv16),
    .Zero(z16), .Carry(c16), .Overflow(o16), .DivZero(dz16), .Erro(e16)
  );

  // flags packed as {Saida_Valida, Pronto, Zero, Carry, Overflow, DivZero, Erro}
  function automatic logic [6:0] flags8();
    return {sv8, p8, z8, c8, o8, dz8, e8};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
  endtask

  // Issue one request on the 8-bit unit; edges = clock edges after the accept edge
  // until Saida_Valida is seen (0 for single-cycle ops).
  task automatic run8(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                      output int edges, output logic p_after);
    sel8 = s; a8 = a; b8 = b; ev8 = 1'b1;
    @(posedge clk); #1;
    ev8 = 1'b0;
    p_after = p8;
    edges = 0;
    while (!sv8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic t8(input string tag, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                    input logic [15:0] exp_res, input int exp_edges, input logic [6:0] exp_flags);
    int edges;
    logic pa;
    run8(s, a, b, edges, pa);
    chk({tag, " res"}, 64'(res8), 64'(exp_res));
    chk({tag, " lat"}, 64'(edges), 64'(exp_edges));
    chk({tag, " flags"}, 64'(flags8()), 64'(exp_flags));
    if (exp_edges > 0) chk({tag, " pronto_low"}, 64'(pa), 64'd0);
  endtask

  initial begin
    int pulses, edges;
    logic [15:0] captured;

    #1 rst_n = 1'b0;
    #1;
    chk("reset res", 64'(res8), 64'd0);
    chk("reset flags", 64'(flags8()), 64'b0110000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    t8("add 50+30",   4'b0000, 8'd50,  8'd30,  16'd80,  0, 7'b1100000);
    t8("add 200+100", 4'b0000, 8'd200, 8'd100, 16'd300, 0, 7'b1101000);
    t8("add 100+100", 4'b0000, 8'd100, 8'd100, 16'd200, 0, 7'b1100100);
    t8("sub 10-20",   4'b0001, 8'd10,  8'd20,  16'd246, 0, 7'b1101000);
    t8("sub 80h-1",   4'b0001, 8'h80,  8'h01,  16'h7F,  0, 7'b1100100);

    t8("mul 3*90",    4'b0010, 8'd3,   8'd90,  16'd270,   8, 7'b1100000);
    @(posedge clk); #1;
    chk("hold res", 64'(res8), 64'd270);
    chk("hold sv", 64'(sv8), 64'd0);
    t8("mul 255*255", 4'b0010, 8'd255, 8'd255, 16'd65025, 8, 7'b1100000);
    t8("mul 0*77",    4'b0010, 8'd0,   8'd77,  16'd0,     8, 7'b1110000);

    t8("quo 100/5",   4'b0011, 8'd100, 8'd5,   16'd20,  8, 7'b1100000);
    t8("rem 23%5",    4'b0100, 8'd23,  8'd5,   16'd3,   8, 7'b1100000);
    t8("quo 7/0",     4'b0011, 8'd7,   8'd0,   16'd255, 0, 7'b1100010);
    t8("rem 9%0",     4'b0100, 8'd9,   8'd0,   16'd9,   0, 7'b1100010);

    t8("and",  4'b0110, 8'hF0, 8'hAA, 16'hA0, 0, 7'b1100000);
    t8("or",   4'b0111, 8'hF0, 8'hAA, 16'hFA, 0, 7'b1100000);
    t8("nand", 4'b1000, 8'hF0, 8'hAA, 16'h5F, 0, 7'b1100000);
    t8("nor",  4'b1001, 8'hF0, 8'hAA, 16'h05, 0, 7'b1100000);
    t8("xor",  4'b1010, 8'hF0, 8'hAA, 16'h5A, 0, 7'b1100000);
    t8("not",  4'b1011, 8'hF0, 8'hAA, 16'h0F, 0, 7'b1100000);

    t8("cmp 50,30", 4'b1100, 8'd50, 8'd30, 16'd2, 0, 7'b1100000);
    t8("cmp 20,80", 4'b1100, 8'd20, 8'd80, 16'd1, 0, 7'b1100000);
    t8("cmp 42,42", 4'b1100, 8'd42, 8'd42, 16'd0, 0, 7'b1110000);
    t8("rsv 0101",  4'b0101, 8'd9,  8'd3,  16'd0, 0, 7'b1110001);
    t8("rsv 1111",  4'b1111, 8'd9,  8'd3,  16'd0, 0, 7'b1110001);

    // Entrada_Valida held through a multiply; operands change after the accept edge.
    sel8 = 4'b0010; a8 = 8'd12; b8 = 8'd11; ev8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd200; b8 = 8'd3;
    pulses = 0; captured = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (sv8) begin pulses++; captured = res8; end
    end
    ev8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (sv8) pulses++;
    end
    chk("held pulses", 64'(pulses), 64'd1);
    chk("held res", 64'(captured), 64'd132);

    // Reset asserted mid-divide.
    sel8 = 4'b0011; a8 = 8'd100; b8 = 8'd5; ev8 = 1'b1;
    @(posedge clk); #1;
    ev8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst res", 64'(res8), 64'd0);
    chk("midrst flags", 64'(flags8()), 64'b0110000);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (sv8) pulses++;
    end
    chk("midrst pulses", 64'(pulses), 64'd0);
    t8("add 1+1", 4'b0000, 8'd1, 8'd1, 16'd2, 0, 7'b1100000);

    // 16-bit instance: full-width multiply.
    sel16 = 4'b0010; a16 = 16'hFFFF; b16 = 16'hFFFF; ev16 = 1'b1;
    @(posedge clk); #1;
    ev16 = 1'b0;
    chk("w16 pronto_low", 64'(p16), 64'd0);
    edges = 0;
    while (!sv16 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("w16 lat", 64'(edges), 64'd16);
    chk("w16 res", 64'(res16), 64'd4294836225);
    chk("w16 flags", 64'({sv16, p16, z16, c16, o16, dz16, e16}), 64'b1100000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
